// File: rtl/button_autorepeat_pkg.sv
// rtl/button_autorepeat_pkg.sv - shared state encoding, default timing and counter sizing for the button front end
package button_autorepeat_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRESS_DB = 3'd1,
      ST_HELD     = 3'd2,
      ST_REP_LOW  = 3'd3,
      ST_REP_HIGH = 3'd4,
      ST_REL_DB   = 3'd5
   } btn_state_t;

   localparam int DEF_N_BTN           = 5;
   localparam int DEF_DEBOUNCE_CYC    = 156_250;
   localparam int DEF_HOLD_CYC        = 15_625_000;
   localparam int DEF_REPEAT_HALF_CYC = 1_562_500;

   // One counter serves every phase, so it is sized for the longest one plus a spare bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/button_autorepeat_channel.sv
// rtl/button_autorepeat_channel.sv - one button: 2-FF synchroniser, debounce/hold/repeat FSM and phase counter
module button_autorepeat_channel
   import button_autorepeat_pkg::*;
#(
   parameter int DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC,
   parameter int HOLD_CYC        = DEF_HOLD_CYC,
   parameter int REPEAT_HALF_CYC = DEF_REPEAT_HALF_CYC,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic btn_out,
   output logic press_pulse,
   output logic repeat_active
);

   localparam int CW = cnt_width(DEBOUNCE_CYC, HOLD_CYC, REPEAT_HALF_CYC);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(REPEAT_HALF_CYC - 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

   logic [1:0]    sync_q;
   logic          s;
   btn_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic          pulse_nxt;

   assign s = sync_q[1];

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q        <= 2'b00;
         state         <= ST_IDLE;
         cnt           <= '0;
         btn_out       <= 1'b0;
         press_pulse   <= 1'b0;
         repeat_active <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], btn_in};
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         btn_out       <= (state_nxt == ST_HELD) || (state_nxt == ST_REP_HIGH);
         press_pulse   <= pulse_nxt;
         repeat_active <= (state_nxt == ST_REP_LOW) || (state_nxt == ST_REP_HIGH);
      end
   end

   always_comb begin
      state_nxt = state;
      pulse_nxt = 1'b0;
      cnt_inc   = (cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
      cnt_nxt   = cnt_inc;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (s) state_nxt = ST_PRESS_DB;
         end
         ST_PRESS_DB: begin
            if (!s) begin
               state_nxt = ST_IDLE;
            end else if (cnt == DB_LAST) begin
               state_nxt = ST_HELD;
               pulse_nxt = 1'b1;
            end
         end
         ST_HELD: begin
            if (!s) state_nxt = ST_REL_DB;
            else if (REPEAT_EN && (cnt == HOLD_LAST)) state_nxt = ST_REP_LOW;
         end
         ST_REP_LOW: begin
            if (!s) begin
               state_nxt = ST_REL_DB;
            end else if (cnt == HALF_LAST) begin
               state_nxt = ST_REP_HIGH;
               pulse_nxt = 1'b1;
            end
         end
         ST_REP_HIGH: begin
            if (!s) state_nxt = ST_REL_DB;
            else if (cnt == HALF_LAST) state_nxt = ST_REP_LOW;
         end
         ST_REL_DB: begin
            // Any bounce high restarts the release window; it never re-arms the press.
            if (s) cnt_nxt = '0;
            else if (cnt == DB_LAST) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
   end

endmodule

// File: rtl/button_autorepeat.sv
// rtl/button_autorepeat.sv - five-button debounce and hold-to-repeat front end for the clock core
module button_autorepeat
   import button_autorepeat_pkg::*;
#(
   parameter int               N_BTN           = DEF_N_BTN,
   parameter int               DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC,
   parameter int               HOLD_CYC        = DEF_HOLD_CYC,
   parameter int               REPEAT_HALF_CYC = DEF_REPEAT_HALF_CYC,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b01111
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_out,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] repeat_active
);

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      button_autorepeat_channel #(
         .DEBOUNCE_CYC    (DEBOUNCE_CYC),
         .HOLD_CYC        (HOLD_CYC),
         .REPEAT_HALF_CYC (REPEAT_HALF_CYC),
         .REPEAT_EN       (REPEAT_MASK[g])
      ) u_ch (
         .clk           (clk),
         .reset_n       (reset_n),
         .btn_in        (btn_in[g]),
         .btn_out       (btn_out[g]),
         .press_pulse   (press_pulse[g]),
         .repeat_active (repeat_active[g])
      );
   end

endmodule

// File: tb/tb_button_autorepeat.sv
// tb/tb_button_autorepeat.sv - directed bench for button_autorepeat with short timing parameters
module tb_button_autorepeat;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] btn_in;
   logic [4:0] btn_out;
   logic [4:0] press_pulse;
   logic [4:0] repeat_active;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pn [5] = '{default: 0};

   button_autorepeat #(
      .N_BTN           (5),
      .DEBOUNCE_CYC    (4),
      .HOLD_CYC        (20),
      .REPEAT_HALF_CYC (5),
      .REPEAT_MASK     (5'b01111)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .btn_in        (btn_in),
      .btn_out       (btn_out),
      .press_pulse   (press_pulse),
      .repeat_active (repeat_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < 5; i++)
         if (press_pulse[i]) pn[i] = pn[i] + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic to_edge(input int n);
      while (cyc < n) tick(1);
   endtask

   // k = edges after the edge that first samples the press
   function automatic logic exp_level(input int k);
      if (k < 6) return 1'b0;
      if (k < 26) return 1'b1;
      return (((k - 26) / 5) % 2) == 1;
   endfunction

   function automatic logic exp_pulse(input int k);
      return (k == 6) || ((k >= 31) && (((k - 31) % 10) == 0));
   endfunction

   initial begin
      int s, f, e1, base0, base3;

      reset_n = 1'b0;
      btn_in  = 5'b0;
      tick(3);
      chk("reset_btn_out", 32'(btn_out), 32'h0);
      chk("reset_press_pulse", 32'(press_pulse), 32'h0);
      chk("reset_repeat_active", 32'(repeat_active), 32'h0);
      #3 reset_n = 1'b1;
      tick(2);

      // clean press on channel 0, held 10 cycles
      base0 = pn[0];
      s = cyc + 1;
      btn_in[0] = 1'b1;
      to_edge(s + 5);
      chk("t1_out_before", 32'(btn_out), 32'h0);
      chk("t1_pulse_before", 32'(press_pulse), 32'h0);
      to_edge(s + 6);
      chk("t1_out_rise", 32'(btn_out), 32'h1);
      chk("t1_pulse", 32'(press_pulse), 32'h1);
      to_edge(s + 7);
      chk("t1_pulse_single", 32'(press_pulse), 32'h0);
      to_edge(s + 9);
      btn_in[0] = 1'b0;
      to_edge(s + 11);
      chk("t1_out_hold", 32'(btn_out[0]), 32'h1);
      to_edge(s + 12);
      chk("t1_out_fall", 32'(btn_out[0]), 32'h0);
      tick(6);
      chk("t1_pulse_count", 32'(pn[0] - base0), 32'd1);
      chk("t1_no_repeat", 32'(repeat_active), 32'h0);

      // bouncing press on channel 2
      base0 = pn[2];
      for (int i = 0; i < 12; i++) begin
         btn_in[2] = (((i / 2) % 2) == 0);
         tick(1);
      end
      btn_in[2] = 1'b1;
      f = cyc + 1;
      to_edge(f + 5);
      chk("t2_out_before", 32'(btn_out[2]), 32'h0);
      chk("t2_pulses_during_bounce", 32'(pn[2] - base0), 32'd0);
      to_edge(f + 6);
      chk("t2_out_rise", 32'(btn_out[2]), 32'h1);
      chk("t2_pulse", 32'(press_pulse[2]), 32'h1);
      btn_in[2] = 1'b0;
      tick(10);
      chk("t2_pulse_count", 32'(pn[2] - base0), 32'd1);
      chk("t2_released", 32'(btn_out[2]), 32'h0);

      // hold-to-repeat on channel 1
      base0 = pn[1];
      s = cyc + 1;
      btn_in[1] = 1'b1;
      for (int k = 1; k <= 55; k++) begin
         to_edge(s + k);
         chk($sformatf("t3_out_k%0d", k), 32'(btn_out[1]), 32'(exp_level(k)));
         chk($sformatf("t3_pulse_k%0d", k), 32'(press_pulse[1]), 32'(exp_pulse(k)));
         chk($sformatf("t3_ra_k%0d", k), 32'(repeat_active[1]), 32'(k >= 26));
      end
      btn_in[1] = 1'b0;
      to_edge(s + 57);
      chk("t3_ra_before_rel", 32'(repeat_active[1]), 32'h1);
      to_edge(s + 58);
      chk("t3_ra_after_rel", 32'(repeat_active[1]), 32'h0);
      chk("t3_out_after_rel", 32'(btn_out[1]), 32'h0);
      tick(8);
      chk("t3_pulse_count", 32'(pn[1] - base0), 32'd4);

      // masked channel 4: no repeat
      base0 = pn[4];
      s = cyc + 1;
      btn_in[4] = 1'b1;
      for (int k = 1; k <= 59; k++) begin
         to_edge(s + k);
         chk($sformatf("t4_out_k%0d", k), 32'(btn_out[4]), 32'(k >= 6));
         chk($sformatf("t4_ra_k%0d", k), 32'(repeat_active[4]), 32'h0);
      end
      btn_in[4] = 1'b0;
      to_edge(s + 61);
      chk("t4_out_hold", 32'(btn_out[4]), 32'h1);
      to_edge(s + 62);
      chk("t4_out_fall", 32'(btn_out[4]), 32'h0);
      tick(6);
      chk("t4_pulse_count", 32'(pn[4] - base0), 32'd1);

      // asynchronous reset while channel 3 is in REP_HIGH
      s = cyc + 1;
      btn_in[3] = 1'b1;
      to_edge(s + 33);
      chk("t5_out_pre_reset", 32'(btn_out[3]), 32'h1);
      chk("t5_ra_pre_reset", 32'(repeat_active[3]), 32'h1);
      #3 reset_n = 1'b0;
      #1;
      chk("t5_async_btn_out", 32'(btn_out), 32'h0);
      chk("t5_async_ra", 32'(repeat_active), 32'h0);
      chk("t5_async_pulse", 32'(press_pulse), 32'h0);
      tick(1);
      chk("t5_held_in_reset", 32'(btn_out), 32'h0);
      #3 reset_n = 1'b1;
      e1 = cyc + 1;
      to_edge(e1 + 5);
      chk("t5_no_early_pulse", 32'(press_pulse[3]), 32'h0);
      chk("t5_no_early_out", 32'(btn_out[3]), 32'h0);
      to_edge(e1 + 6);
      chk("t5_pulse_after_reset", 32'(press_pulse[3]), 32'h1);
      btn_in[3] = 1'b0;
      tick(10);

      // simultaneous press on channels 0 and 3
      base0 = pn[0];
      base3 = pn[3];
      s = cyc + 1;
      btn_in = 5'b01001;
      for (int k = 1; k <= 44; k++) begin
         to_edge(s + k);
         chk($sformatf("t6_out0_k%0d", k), 32'(btn_out[0]), 32'(exp_level(k)));
         chk($sformatf("t6_out3_k%0d", k), 32'(btn_out[3]), 32'(exp_level(k)));
         chk($sformatf("t6_pulse0_k%0d", k), 32'(press_pulse[0]), 32'(exp_pulse(k)));
         chk($sformatf("t6_pulse3_k%0d", k), 32'(press_pulse[3]), 32'(exp_pulse(k)));
      end
      btn_in = 5'b0;
      tick(10);
      chk("t6_pulse_count0", 32'(pn[0] - base0), 32'd3);
      chk("t6_pulse_count3", 32'(pn[3] - base3), 32'd3);
      chk("t6_idle_outputs", 32'({btn_out, repeat_active}), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
